addsub_seq_psw: RTL

//  Parametrised multicycle add/subtract unit with a registered PSW carry. Next-generation ALU adder stage for the multicycle RISC datapath.

---
 rtl/addsub_seq_psw_pkg.sv | 18 +
 rtl/addsub_slice.sv | 17 +
 rtl/addsub_seq_psw.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_psw_pkg.sv
// Shared definitions for the sliced add/subtract unit: FSM state encodings
// and the slice-counter width helper.
package addsub_seq_psw_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The counter needs at least one bit even when a single slice covers the word.
  function automatic int cnt_width(input int nslice);
    if (nslice > 1) begin
      return $clog2(nslice);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit adder with carry in/out, reused by the
// sequential add/subtract unit on every RUN cycle.
module addsub_slice
  import addsub_seq_psw_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/addsub_seq_psw.sv
// Multicycle add/subtract unit: SLICE bits per clock, LSB first, with a
// registered PSW carry. Define ALU_OVF_EN to add the signed-overflow flag v.
module addsub_seq_psw
  import addsub_seq_psw_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             use_c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             z,
  output logic             n,
  output logic             psw_c
`ifdef ALU_OVF_EN
  ,
  output logic             v
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_width_check
      $error("addsub_seq_psw: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_next_s;
  logic [SLICE-1:0] a_slice_s;
  logic [SLICE-1:0] b_slice_s;
  logic [SLICE-1:0] slice_sum_s;
  logic             slice_cout_s;
  logic             accept_s;
  logic             last_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             z_r;
  logic             n_r;
  logic             psw_c_r;

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_slice_s),
    .b    (b_slice_s),
    .cin  (carry_r),
    .s    (slice_sum_s),
    .cout (slice_cout_s)
  );

  assign accept_s = start & ((state_r == S_IDLE) | (state_r == S_DONE));
  assign last_s   = (state_r == S_RUN) & (cnt_r == CNT_LAST);

  // Select the active operand slice and merge its sum into the result word.
  always_comb begin
    a_slice_s  = {SLICE{1'b0}};
    b_slice_s  = {SLICE{1'b0}};
    res_next_s = res_r;
    for (int k = 0; k < NSLICE; k++) begin
      a_slice_s = a_slice_s | (a_r[k*SLICE +: SLICE] & {SLICE{cnt_r == CNT_W'(k)}});
      b_slice_s = b_slice_s | (b_r[k*SLICE +: SLICE] & {SLICE{cnt_r == CNT_W'(k)}});
      res_next_s[k*SLICE +: SLICE] = (cnt_r == CNT_W'(k)) ? slice_sum_s
                                                           : res_r[k*SLICE +: SLICE];
    end
  end

  // FSM next-state; start is only honoured from IDLE or DONE.
  always_comb begin
    next_state_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_RUN;
        else       next_state_s = S_IDLE;
      end
      S_RUN: begin
        if (last_s) next_state_s = S_DONE;
        else        next_state_s = S_RUN;
      end
      S_DONE: begin
        if (start) next_state_s = S_RUN;
        else       next_state_s = S_IDLE;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State, status pulses and the per-slice datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      res_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == S_RUN);
      done_r  <= last_s;
      if (accept_s) begin
        // Subtraction is A + ~B; the +1 comes through the initial carry.
        a_r     <= a;
        b_r     <= b ^ {WIDTH{sub}};
        carry_r <= use_c ? psw_c_r : sub;
        cnt_r   <= {CNT_W{1'b0}};
        res_r   <= {WIDTH{1'b0}};
      end else if (state_r == S_RUN) begin
        carry_r <= slice_cout_s;
        res_r   <= res_next_s;
        cnt_r   <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      end
    end
  end

  // Result and PSW flags, updated only on the final slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      z_r     <= 1'b0;
      n_r     <= 1'b0;
      psw_c_r <= 1'b0;
    end else if (last_s) begin
      sum_r   <= res_next_s;
      cout_r  <= slice_cout_s;
      z_r     <= ~|res_next_s;
      n_r     <= res_next_s[WIDTH-1];
      psw_c_r <= slice_cout_s;
    end
  end

`ifdef ALU_OVF_EN
  logic v_r;

  // Signed overflow: like-signed operands producing an opposite-signed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= 1'b0;
    end else if (last_s) begin
      v_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_next_s[WIDTH-1] != a_r[WIDTH-1]);
    end
  end

  assign v = v_r;
`endif

  assign busy  = busy_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign cout  = cout_r;
  assign z     = z_r;
  assign n     = n_r;
  assign psw_c = psw_c_r;

endmodule
